// File: rtl/issue_unit_pkg.sv
// -----------------------------------------------------------------------------
// issue_unit_pkg
// Shared configuration for the issue stage: ROB tag width, opcode-class width,
// opcode-class encodings, the operand-source selector used by the resolver and
// small helper functions.
// -----------------------------------------------------------------------------
package issue_unit_pkg;

  // Tag/opcode widths shared by the whole core.
  localparam int CFG_ROB_LOG = 4;
  localparam int CFG_OP_LOG  = 6;

  // Opcode classes carried in issue_op.
  typedef enum logic [CFG_OP_LOG-1:0] {
    OPC_NOP    = 6'd0,
    OPC_ALU    = 6'd1,
    OPC_ALUI   = 6'd2,
    OPC_LOAD   = 6'd3,
    OPC_STORE  = 6'd4,
    OPC_BRANCH = 6'd5,
    OPC_JAL    = 6'd6,
    OPC_JALR   = 6'd7,
    OPC_LUI    = 6'd8,
    OPC_AUIPC  = 6'd9
  } op_class_e;

  // Where a source operand's value comes from in the issue cycle.
  typedef enum logic [2:0] {
    SRC_NONE = 3'd0,  // unused source or x0: constant zero
    SRC_RF   = 3'd1,  // architectural value, register not renamed
    SRC_EXC  = 3'd2,  // ALU broadcast this cycle
    SRC_LSB  = 3'd3,  // LSB broadcast this cycle
    SRC_ROB  = 3'd4,  // already completed, value parked in the ROB
    SRC_WAIT = 3'd5   // still in flight: forward the tag
  } src_sel_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // True for the hard-wired zero register.
  function automatic logic is_x0(input logic [4:0] idx);
    return (idx == REG_ZERO);
  endfunction

  // Saturating increment for 32-bit event counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic en);
    logic [31:0] res;
    if (en && (cnt != 32'hFFFF_FFFF)) begin
      res = cnt + 32'd1;
    end else begin
      res = cnt;
    end
    return res;
  endfunction

endpackage

// File: rtl/issue_unit_if.sv
// -----------------------------------------------------------------------------
// issue_unit_if
// Registered issue bundle from the issue stage to the reservation station and
// the load/store buffer.
//   issue_valid / lsb_issue_valid : one-cycle write strobes (RS / LSB)
//   issue_op                      : opcode class
//   issue_Vj/Vk, issue_Rj/Rk      : operand values and ready flags
//   issue_Qj/Qk                   : ROB tags of operands still in flight
//   issue_Imm, issue_CurPC        : immediate and instruction PC
//   issue_DestRob                 : ROB entry allocated to the instruction
// Modports: master (issue unit drives), slave (RS/LSB side reads).
// -----------------------------------------------------------------------------
interface issue_unit_if
  import issue_unit_pkg::*;
#(
  parameter int ROB_LOG = CFG_ROB_LOG,
  parameter int OP_LOG  = CFG_OP_LOG
);

  logic               issue_valid;
  logic               lsb_issue_valid;
  logic [OP_LOG-1:0]  issue_op;
  logic [31:0]        issue_Vj;
  logic [31:0]        issue_Vk;
  logic               issue_Rj;
  logic               issue_Rk;
  logic [ROB_LOG-1:0] issue_Qj;
  logic [ROB_LOG-1:0] issue_Qk;
  logic [31:0]        issue_Imm;
  logic [31:0]        issue_CurPC;
  logic [ROB_LOG-1:0] issue_DestRob;

  modport master (
    output issue_valid, lsb_issue_valid, issue_op,
           issue_Vj, issue_Vk, issue_Rj, issue_Rk, issue_Qj, issue_Qk,
           issue_Imm, issue_CurPC, issue_DestRob
  );

  modport slave (
    input  issue_valid, lsb_issue_valid, issue_op,
           issue_Vj, issue_Vk, issue_Rj, issue_Rk, issue_Qj, issue_Qk,
           issue_Imm, issue_CurPC, issue_DestRob
  );

endinterface

// File: rtl/issue_unit_operand_resolve.sv
// -----------------------------------------------------------------------------
// issue_operand_resolve
// Combinational value-or-tag resolution of one source operand at issue.
// Priority (first match wins): unused/x0, not renamed, ALU broadcast,
// LSB broadcast, ROB already holds the result, otherwise wait on the tag.
// Ports:
//   use_src, rs               : source used flag and register index
//   busy, tag, rf_val         : register-file rename lookup for rs
//   rob_ready, rob_val        : ROB lookup at tag
//   exc_valid/exc_rob_id/...  : ALU broadcast bus
//   lsb_valid/lsb_rob_id/...  : LSB broadcast bus
//   ready, value, qtag        : resolved operand (R, V, Q)
// -----------------------------------------------------------------------------
module issue_operand_resolve
  import issue_unit_pkg::*;
#(
  parameter int ROB_LOG = CFG_ROB_LOG
) (
  input  logic               use_src,
  input  logic [4:0]         rs,
  input  logic               busy,
  input  logic [ROB_LOG-1:0] tag,
  input  logic [31:0]        rf_val,
  input  logic               rob_ready,
  input  logic [31:0]        rob_val,
  input  logic               exc_valid,
  input  logic [ROB_LOG-1:0] exc_rob_id,
  input  logic [31:0]        exc_value,
  input  logic               lsb_valid,
  input  logic [ROB_LOG-1:0] lsb_rob_id,
  input  logic [31:0]        lsb_value,
  output logic               ready,
  output logic [31:0]        value,
  output logic [ROB_LOG-1:0] qtag
);

  src_sel_e sel_s;

  // Pick the operand source; broadcasts beat the ROB copy so a result
  // produced this very cycle is caught even before the ROB records it.
  always_comb begin
    sel_s = SRC_WAIT;
    if (!use_src || is_x0(rs)) begin
      sel_s = SRC_NONE;
    end else if (!busy) begin
      sel_s = SRC_RF;
    end else if (exc_valid && (exc_rob_id == tag)) begin
      sel_s = SRC_EXC;
    end else if (lsb_valid && (lsb_rob_id == tag)) begin
      sel_s = SRC_LSB;
    end else if (rob_ready) begin
      sel_s = SRC_ROB;
    end else begin
      sel_s = SRC_WAIT;
    end
  end

  // Turn the selected source into the R/V/Q triple.
  always_comb begin
    ready = 1'b1;
    value = 32'd0;
    qtag  = {ROB_LOG{1'b0}};
    case (sel_s)
      SRC_NONE: begin
        ready = 1'b1;
        value = 32'd0;
      end
      SRC_RF:  value = rf_val;
      SRC_EXC: value = exc_value;
      SRC_LSB: value = lsb_value;
      SRC_ROB: value = rob_val;
      SRC_WAIT: begin
        ready = 1'b0;
        qtag  = tag;
      end
      default: begin
        ready = 1'b0;
        value = 32'd0;
        qtag  = tag;
      end
    endcase
  end

endmodule

// File: rtl/issue_unit.sv
// -----------------------------------------------------------------------------
// issue_unit
// In-order issue stage of the Tomasulo core. Takes the instruction-queue head,
// allocates a ROB entry, renames rd, resolves both sources to value-or-tag and
// drives the registered issue bundle to the RS or the LSB.
// Ports:
//   clk, rst (async, active-low), rdy (global stall when low)
//   iq_*          : instruction-queue head; iq_pop dequeues it (comb)
//   rf_*          : rename lookups for rs1/rs2
//   rob_*         : ROB lookups, allocation tail and full flag; rob_alloc (comb)
//   rename_*      : rename write of rd with the allocated tag (comb)
//   RS_next_full, LSB_next_full : target full flags
//   exc_*, LSB_*  : ALU / LSB result broadcast buses
//   jump_flag     : misprediction flush
//   iss           : registered issue bundle (issue_unit_if.master)
// Optional build macro ISSUE_STALL_CNT_EN adds saturating stall counters
// stall_rob_cnt / stall_rs_cnt / stall_lsb_cnt.
// -----------------------------------------------------------------------------
module issue_unit
  import issue_unit_pkg::*;
#(
  parameter int ROB_LOG = CFG_ROB_LOG,
  parameter int OP_LOG  = CFG_OP_LOG
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  // instruction queue head
  input  logic               iq_valid,
  input  logic [OP_LOG-1:0]  iq_op,
  input  logic [4:0]         iq_rd,
  input  logic [4:0]         iq_rs1,
  input  logic [4:0]         iq_rs2,
  input  logic               iq_use_rs1,
  input  logic               iq_use_rs2,
  input  logic               iq_is_ls,
  input  logic [31:0]        iq_imm,
  input  logic [31:0]        iq_pc,
  output logic               iq_pop,
  // register file rename lookups
  input  logic               rf_busy1,
  input  logic               rf_busy2,
  input  logic [ROB_LOG-1:0] rf_tag1,
  input  logic [ROB_LOG-1:0] rf_tag2,
  input  logic [31:0]        rf_val1,
  input  logic [31:0]        rf_val2,
  // reorder buffer
  input  logic               rob_ready1,
  input  logic               rob_ready2,
  input  logic [31:0]        rob_val1,
  input  logic [31:0]        rob_val2,
  input  logic [ROB_LOG-1:0] rob_tail,
  input  logic               rob_next_full,
  output logic               rob_alloc,
  // rename write
  output logic               rename_valid,
  output logic [4:0]         rename_rd,
  output logic [ROB_LOG-1:0] rename_tag,
  // targets
  input  logic               RS_next_full,
  input  logic               LSB_next_full,
  // broadcast buses
  input  logic               exc_valid,
  input  logic [ROB_LOG-1:0] exc_RobId,
  input  logic [31:0]        exc_value,
  input  logic               LSB_valid,
  input  logic [ROB_LOG-1:0] LSB_RobId,
  input  logic [31:0]        LSB_value,
  input  logic               jump_flag,
  // registered issue bundle
  issue_unit_if.master       iss
`ifdef ISSUE_STALL_CNT_EN
  ,
  output logic [31:0]        stall_rob_cnt,
  output logic [31:0]        stall_rs_cnt,
  output logic [31:0]        stall_lsb_cnt
`endif
);

  logic               target_full_s;
  logic               fire_s;

  logic               rj_s;
  logic               rk_s;
  logic [31:0]        vj_s;
  logic [31:0]        vk_s;
  logic [ROB_LOG-1:0] qj_s;
  logic [ROB_LOG-1:0] qk_s;

  logic               valid_r;
  logic               lsb_valid_r;
  logic [OP_LOG-1:0]  op_r;
  logic [31:0]        vj_r;
  logic [31:0]        vk_r;
  logic               rj_r;
  logic               rk_r;
  logic [ROB_LOG-1:0] qj_r;
  logic [ROB_LOG-1:0] qk_r;
  logic [31:0]        imm_r;
  logic [31:0]        pc_r;
  logic [ROB_LOG-1:0] dest_r;

  // Select the full flag of the structure this instruction is headed for.
  always_comb begin
    target_full_s = 1'b0;
    if (iq_is_ls) begin
      target_full_s = LSB_next_full;
    end else begin
      target_full_s = RS_next_full;
    end
  end

  // Gating with rst keeps every handshake output low while in reset; the
  // flush wins over an otherwise valid fire.
  assign fire_s = rst & rdy & ~jump_flag & iq_valid & ~rob_next_full & ~target_full_s;

  assign iq_pop       = fire_s;
  assign rob_alloc    = fire_s;
  assign rename_valid = fire_s & ~is_x0(iq_rd);

  // Rename index/tag follow the queue head outside reset.
  always_comb begin
    rename_rd  = 5'd0;
    rename_tag = {ROB_LOG{1'b0}};
    if (rst) begin
      rename_rd  = iq_rd;
      rename_tag = rob_tail;
    end else begin
      rename_rd  = 5'd0;
      rename_tag = {ROB_LOG{1'b0}};
    end
  end

  issue_operand_resolve #(.ROB_LOG(ROB_LOG)) u_resolve_rs1 (
    .use_src    (iq_use_rs1),
    .rs         (iq_rs1),
    .busy       (rf_busy1),
    .tag        (rf_tag1),
    .rf_val     (rf_val1),
    .rob_ready  (rob_ready1),
    .rob_val    (rob_val1),
    .exc_valid  (exc_valid),
    .exc_rob_id (exc_RobId),
    .exc_value  (exc_value),
    .lsb_valid  (LSB_valid),
    .lsb_rob_id (LSB_RobId),
    .lsb_value  (LSB_value),
    .ready      (rj_s),
    .value      (vj_s),
    .qtag       (qj_s)
  );

  issue_operand_resolve #(.ROB_LOG(ROB_LOG)) u_resolve_rs2 (
    .use_src    (iq_use_rs2),
    .rs         (iq_rs2),
    .busy       (rf_busy2),
    .tag        (rf_tag2),
    .rf_val     (rf_val2),
    .rob_ready  (rob_ready2),
    .rob_val    (rob_val2),
    .exc_valid  (exc_valid),
    .exc_rob_id (exc_RobId),
    .exc_value  (exc_value),
    .lsb_valid  (LSB_valid),
    .lsb_rob_id (LSB_RobId),
    .lsb_value  (LSB_value),
    .ready      (rk_s),
    .value      (vk_s),
    .qtag       (qk_s)
  );

  // Issue bundle register: strobes pulse for one cycle per fire, payload
  // only loads on fire so it holds across stalls and flushes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r     <= 1'b0;
      lsb_valid_r <= 1'b0;
      op_r        <= {OP_LOG{1'b0}};
      vj_r        <= 32'd0;
      vk_r        <= 32'd0;
      rj_r        <= 1'b0;
      rk_r        <= 1'b0;
      qj_r        <= {ROB_LOG{1'b0}};
      qk_r        <= {ROB_LOG{1'b0}};
      imm_r       <= 32'd0;
      pc_r        <= 32'd0;
      dest_r      <= {ROB_LOG{1'b0}};
    end else begin
      valid_r     <= fire_s & ~iq_is_ls;
      lsb_valid_r <= fire_s & iq_is_ls;
      if (fire_s) begin
        op_r   <= iq_op;
        vj_r   <= vj_s;
        vk_r   <= vk_s;
        rj_r   <= rj_s;
        rk_r   <= rk_s;
        qj_r   <= qj_s;
        qk_r   <= qk_s;
        imm_r  <= iq_imm;
        pc_r   <= iq_pc;
        dest_r <= rob_tail;
      end
    end
  end

  assign iss.issue_valid     = valid_r;
  assign iss.lsb_issue_valid = lsb_valid_r;
  assign iss.issue_op        = op_r;
  assign iss.issue_Vj        = vj_r;
  assign iss.issue_Vk        = vk_r;
  assign iss.issue_Rj        = rj_r;
  assign iss.issue_Rk        = rk_r;
  assign iss.issue_Qj        = qj_r;
  assign iss.issue_Qk        = qk_r;
  assign iss.issue_Imm       = imm_r;
  assign iss.issue_CurPC     = pc_r;
  assign iss.issue_DestRob   = dest_r;

`ifdef ISSUE_STALL_CNT_EN
  logic        stall_rob_s;
  logic        stall_rs_s;
  logic        stall_lsb_s;
  logic [31:0] stall_rob_r;
  logic [31:0] stall_rs_r;
  logic [31:0] stall_lsb_r;

  // Attribute a stalled valid head to one cause: ROB first, then target.
  always_comb begin
    stall_rob_s = 1'b0;
    stall_rs_s  = 1'b0;
    stall_lsb_s = 1'b0;
    if (rdy && !jump_flag && iq_valid) begin
      if (rob_next_full) begin
        stall_rob_s = 1'b1;
      end else if (target_full_s) begin
        if (iq_is_ls) begin
          stall_lsb_s = 1'b1;
        end else begin
          stall_rs_s = 1'b1;
        end
      end else begin
        stall_rob_s = 1'b0;
      end
    end else begin
      stall_rob_s = 1'b0;
    end
  end

  // Saturating stall counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_rob_r <= 32'd0;
      stall_rs_r  <= 32'd0;
      stall_lsb_r <= 32'd0;
    end else begin
      stall_rob_r <= sat_inc(stall_rob_r, stall_rob_s);
      stall_rs_r  <= sat_inc(stall_rs_r, stall_rs_s);
      stall_lsb_r <= sat_inc(stall_lsb_r, stall_lsb_s);
    end
  end

  assign stall_rob_cnt = stall_rob_r;
  assign stall_rs_cnt  = stall_rs_r;
  assign stall_lsb_cnt = stall_lsb_r;
`endif

endmodule

// File: tb/tb_issue_unit.sv
// -----------------------------------------------------------------------------
// tb_issue_unit
// Self-checking bench for issue_unit: directed scenarios plus a randomized
// run checked against a behavioural model of the issue rules.
// -----------------------------------------------------------------------------
module tb_issue_unit;
  import issue_unit_pkg::*;

  localparam int RL = 4;
  localparam int OL = 6;
  localparam int BW = 150;

  logic clk, rst, rdy, iq_valid, iq_use_rs1, iq_use_rs2, iq_is_ls, iq_pop;
  logic [OL-1:0] iq_op;
  logic [4:0] iq_rd, iq_rs1, iq_rs2, rename_rd;
  logic [31:0] iq_imm, iq_pc, rf_val1, rf_val2, rob_val1, rob_val2, exc_value, LSB_value;
  logic rf_busy1, rf_busy2, rob_ready1, rob_ready2, rob_next_full, rob_alloc, rename_valid;
  logic [RL-1:0] rf_tag1, rf_tag2, rob_tail, rename_tag, exc_RobId, LSB_RobId;
  logic RS_next_full, LSB_next_full, exc_valid, LSB_valid, jump_flag;
`ifdef ISSUE_STALL_CNT_EN
  logic [31:0] stall_rob_cnt, stall_rs_cnt, stall_lsb_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  issue_unit_if #(.ROB_LOG(RL), .OP_LOG(OL)) ifc ();

  issue_unit #(.ROB_LOG(RL), .OP_LOG(OL)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .iq_valid(iq_valid), .iq_op(iq_op), .iq_rd(iq_rd), .iq_rs1(iq_rs1), .iq_rs2(iq_rs2),
    .iq_use_rs1(iq_use_rs1), .iq_use_rs2(iq_use_rs2), .iq_is_ls(iq_is_ls),
    .iq_imm(iq_imm), .iq_pc(iq_pc), .iq_pop(iq_pop),
    .rf_busy1(rf_busy1), .rf_busy2(rf_busy2), .rf_tag1(rf_tag1), .rf_tag2(rf_tag2),
    .rf_val1(rf_val1), .rf_val2(rf_val2),
    .rob_ready1(rob_ready1), .rob_ready2(rob_ready2), .rob_val1(rob_val1), .rob_val2(rob_val2),
    .rob_tail(rob_tail), .rob_next_full(rob_next_full), .rob_alloc(rob_alloc),
    .rename_valid(rename_valid), .rename_rd(rename_rd), .rename_tag(rename_tag),
    .RS_next_full(RS_next_full), .LSB_next_full(LSB_next_full),
    .exc_valid(exc_valid), .exc_RobId(exc_RobId), .exc_value(exc_value),
    .LSB_valid(LSB_valid), .LSB_RobId(LSB_RobId), .LSB_value(LSB_value),
    .jump_flag(jump_flag),
    .iss(ifc)
`ifdef ISSUE_STALL_CNT_EN
    , .stall_rob_cnt(stall_rob_cnt), .stall_rs_cnt(stall_rs_cnt), .stall_lsb_cnt(stall_lsb_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rdy = 1'b1; jump_flag = 1'b0; iq_valid = 1'b0; iq_op = 6'd0;
    iq_rd = 5'd0; iq_rs1 = 5'd0; iq_rs2 = 5'd0; iq_use_rs1 = 1'b0; iq_use_rs2 = 1'b0;
    iq_is_ls = 1'b0; iq_imm = 32'd0; iq_pc = 32'd0;
    rf_busy1 = 1'b0; rf_busy2 = 1'b0; rf_tag1 = 4'd0; rf_tag2 = 4'd0;
    rf_val1 = 32'd0; rf_val2 = 32'd0; rob_ready1 = 1'b0; rob_ready2 = 1'b0;
    rob_val1 = 32'd0; rob_val2 = 32'd0; rob_tail = 4'd0; rob_next_full = 1'b0;
    RS_next_full = 1'b0; LSB_next_full = 1'b0;
    exc_valid = 1'b0; exc_RobId = 4'd0; exc_value = 32'd0;
    LSB_valid = 1'b0; LSB_RobId = 4'd0; LSB_value = 32'd0;
  endtask

  function automatic logic [BW-1:0] bundle();
    return {ifc.issue_valid, ifc.lsb_issue_valid, ifc.issue_op, ifc.issue_Vj, ifc.issue_Vk,
            ifc.issue_Rj, ifc.issue_Rk, ifc.issue_Qj, ifc.issue_Qk,
            ifc.issue_Imm, ifc.issue_CurPC, ifc.issue_DestRob};
  endfunction

  function automatic logic [11:0] comb_out();
    return {iq_pop, rob_alloc, rename_valid, rename_rd, rename_tag};
  endfunction

  // Reference rule for one operand: returns {R, V, Q}.
  function automatic logic [36:0] ref_resolve(
      input logic use_src, input logic [4:0] rs, input logic busy, input logic [3:0] tag,
      input logic [31:0] val, input logic rready, input logic [31:0] rval,
      input logic ev, input logic [3:0] eid, input logic [31:0] evl,
      input logic lv, input logic [3:0] lid, input logic [31:0] lvl);
    if (!use_src || rs == 5'd0) return {1'b1, 32'd0, 4'd0};
    if (!busy) return {1'b1, val, 4'd0};
    if (ev && eid == tag) return {1'b1, evl, 4'd0};
    if (lv && lid == tag) return {1'b1, lvl, 4'd0};
    if (rready) return {1'b1, rval, 4'd0};
    return {1'b0, 32'd0, tag};
  endfunction

  // Reset holds everything low even with a valid head; first fire after release.
  task automatic test_reset();
    idle();
    rst = 1'b1;
    #2 rst = 1'b0;
    iq_valid = 1'b1; iq_rd = 5'd9; rob_tail = 4'd5; iq_imm = 32'hDEAD; iq_use_rs1 = 1'b1;
    iq_rs1 = 5'd1; rf_val1 = 32'd11;
    #1;
    n_cmp++;
    if (comb_out() !== 12'd0) begin
      n_err++; $display("FAIL reset_comb: got %h want 000", comb_out());
    end
    tick();
    n_cmp++;
    if (bundle() !== {BW{1'b0}}) begin
      n_err++; $display("FAIL reset_regs: got %h want 0", bundle());
    end
`ifdef ISSUE_STALL_CNT_EN
    n_cmp++;
    if ({stall_rob_cnt, stall_rs_cnt, stall_lsb_cnt} !== 96'd0) begin
      n_err++; $display("FAIL reset_cnt: got %h/%h/%h want 0", stall_rob_cnt, stall_rs_cnt, stall_lsb_cnt);
    end
`endif
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({iq_pop, rename_valid, rename_rd, rename_tag} !== {1'b1, 1'b1, 5'd9, 4'd5}) begin
      n_err++; $display("FAIL reset_release_comb: got pop=%b rv=%b rd=%0d tag=%0d want 1 1 9 5",
                        iq_pop, rename_valid, rename_rd, rename_tag);
    end
    tick();
    idle();
    n_cmp++;
    if ({ifc.issue_valid, ifc.lsb_issue_valid, ifc.issue_DestRob, ifc.issue_Imm, ifc.issue_Vj}
        !== {1'b1, 1'b0, 4'd5, 32'hDEAD, 32'd11}) begin
      n_err++; $display("FAIL reset_first_fire: got v=%b lv=%b dest=%0d imm=%h vj=%0d want 1 0 5 dead 11",
                        ifc.issue_valid, ifc.lsb_issue_valid, ifc.issue_DestRob, ifc.issue_Imm, ifc.issue_Vj);
    end
  endtask

  task automatic setup_add();
    idle();
    iq_valid = 1'b1; iq_op = OPC_ALU; iq_rd = 5'd3; iq_rs1 = 5'd1; iq_rs2 = 5'd2;
    iq_use_rs1 = 1'b1; iq_use_rs2 = 1'b1; iq_pc = 32'h100;
    rf_busy1 = 1'b0; rf_val1 = 32'd5; rf_busy2 = 1'b1; rf_tag2 = 4'd7; rob_ready2 = 1'b0;
    rob_tail = 4'd2;
  endtask

  // ADD x3, x1, x2 with x2 waiting on tag 7.
  task automatic test_add();
    setup_add();
    #1;
    n_cmp++;
    if (comb_out() !== {1'b1, 1'b1, 1'b1, 5'd3, 4'd2}) begin
      n_err++; $display("FAIL add_comb: got %h want %h", comb_out(), {1'b1, 1'b1, 1'b1, 5'd3, 4'd2});
    end
    tick();
    idle();
    n_cmp++;
    if ({ifc.issue_valid, ifc.lsb_issue_valid, ifc.issue_Vj, ifc.issue_Rj, ifc.issue_Qj,
         ifc.issue_Vk, ifc.issue_Rk, ifc.issue_Qk, ifc.issue_DestRob, ifc.issue_op, ifc.issue_CurPC}
        !== {1'b1, 1'b0, 32'd5, 1'b1, 4'd0, 32'd0, 1'b0, 4'd7, 4'd2, 6'(OPC_ALU), 32'h100}) begin
      n_err++; $display("FAIL add_payload: got v=%b vj=%0d rj=%b vk=%0d rk=%b qk=%0d dest=%0d want 1 5 1 0 0 7 2",
                        ifc.issue_valid, ifc.issue_Vj, ifc.issue_Rj, ifc.issue_Vk, ifc.issue_Rk,
                        ifc.issue_Qk, ifc.issue_DestRob);
    end
    tick();
    n_cmp++;
    if ({ifc.issue_valid, ifc.issue_Vj, ifc.issue_Qk, ifc.issue_DestRob} !== {1'b0, 32'd5, 4'd7, 4'd2}) begin
      n_err++; $display("FAIL add_hold: got v=%b vj=%0d qk=%0d dest=%0d want 0 5 7 2",
                        ifc.issue_valid, ifc.issue_Vj, ifc.issue_Qk, ifc.issue_DestRob);
    end
  endtask

  // Broadcast snooping and source priority on the rs2 operand.
  task automatic test_bypass();
    logic [36:0] want;
    for (int k = 0; k < 5; k++) begin
      setup_add();
      case (k)
        0: begin exc_valid = 1'b1; exc_RobId = 4'd7; exc_value = 32'h1234; want = {1'b1, 32'h1234, 4'd0}; end
        1: begin LSB_valid = 1'b1; LSB_RobId = 4'd7; LSB_value = 32'h5678; want = {1'b1, 32'h5678, 4'd0}; end
        2: begin rob_ready2 = 1'b1; rob_val2 = 32'h9ABC; want = {1'b1, 32'h9ABC, 4'd0}; end
        3: begin
          exc_valid = 1'b1; exc_RobId = 4'd7; exc_value = 32'h1234;
          LSB_valid = 1'b1; LSB_RobId = 4'd7; LSB_value = 32'h5678;
          rob_ready2 = 1'b1; rob_val2 = 32'h9ABC; want = {1'b1, 32'h1234, 4'd0};
        end
        default: begin exc_valid = 1'b1; exc_RobId = 4'd6; exc_value = 32'h1111; want = {1'b0, 32'd0, 4'd7}; end
      endcase
      #1;
      tick();
      n_cmp++;
      if ({ifc.issue_valid, ifc.issue_Rk, ifc.issue_Vk, ifc.issue_Qk, ifc.issue_Vj} !== {1'b1, want, 32'd5}) begin
        n_err++; $display("FAIL bypass_%0d: got v=%b rk=%b vk=%h qk=%0d vj=%0d want 1 %b %h %0d 5", k,
                          ifc.issue_valid, ifc.issue_Rk, ifc.issue_Vk, ifc.issue_Qk, ifc.issue_Vj,
                          want[36], want[35:4], want[3:0]);
      end
    end
    idle();
  endtask

  // LW x0, 4(x1) blocked by LSB_next_full for two cycles.
  task automatic test_lsb_stall();
    idle();
    iq_valid = 1'b1; iq_op = OPC_LOAD; iq_is_ls = 1'b1; iq_rd = 5'd0; iq_rs1 = 5'd1;
    iq_use_rs1 = 1'b1; rf_val1 = 32'h40; iq_imm = 32'd4; rob_tail = 4'd9; LSB_next_full = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++;
      if ({iq_pop, rob_alloc} !== 2'b00) begin
        n_err++; $display("FAIL lsb_stall_pop_%0d: got pop=%b alloc=%b want 0 0", c, iq_pop, rob_alloc);
      end
      tick();
      n_cmp++;
      if ({ifc.issue_valid, ifc.lsb_issue_valid} !== 2'b00) begin
        n_err++; $display("FAIL lsb_stall_strobe_%0d: got %b%b want 00", c, ifc.issue_valid, ifc.lsb_issue_valid);
      end
    end
    LSB_next_full = 1'b0;
    #1;
    n_cmp++;
    if ({iq_pop, rename_valid} !== 2'b10) begin
      n_err++; $display("FAIL lsb_fire_comb: got pop=%b rv=%b want 1 0", iq_pop, rename_valid);
    end
    tick();
    idle();
    n_cmp++;
    if ({ifc.issue_valid, ifc.lsb_issue_valid, ifc.issue_Imm, ifc.issue_Vj, ifc.issue_DestRob}
        !== {1'b0, 1'b1, 32'd4, 32'h40, 4'd9}) begin
      n_err++; $display("FAIL lsb_fire_payload: got v=%b lv=%b imm=%0d vj=%h dest=%0d want 0 1 4 40 9",
                        ifc.issue_valid, ifc.lsb_issue_valid, ifc.issue_Imm, ifc.issue_Vj, ifc.issue_DestRob);
    end
  endtask

  // Flush and rdy stall: no fire, strobes low, payload held.
  task automatic test_flush();
    idle();
    iq_valid = 1'b1; iq_rd = 5'd4; iq_imm = 32'h77; rob_tail = 4'd1;
    tick();
    iq_imm = 32'h88; jump_flag = 1'b1;
    #1;
    n_cmp++;
    if ({iq_pop, rob_alloc, rename_valid} !== 3'b000) begin
      n_err++; $display("FAIL flush_comb: got pop=%b alloc=%b rv=%b want 000", iq_pop, rob_alloc, rename_valid);
    end
    tick();
    n_cmp++;
    if ({ifc.issue_valid, ifc.lsb_issue_valid, ifc.issue_Imm} !== {2'b00, 32'h77}) begin
      n_err++; $display("FAIL flush_regs: got %b%b imm=%h want 00 77", ifc.issue_valid, ifc.lsb_issue_valid, ifc.issue_Imm);
    end
    jump_flag = 1'b0; rdy = 1'b0; iq_imm = 32'h99;
    #1;
    n_cmp++;
    if (iq_pop !== 1'b0) begin
      n_err++; $display("FAIL rdy_stall_comb: got pop=%b want 0", iq_pop);
    end
    tick();
    idle();
    n_cmp++;
    if ({ifc.issue_valid, ifc.lsb_issue_valid, ifc.issue_Imm} !== {2'b00, 32'h77}) begin
      n_err++; $display("FAIL rdy_stall_regs: got %b%b imm=%h want 00 77", ifc.issue_valid, ifc.lsb_issue_valid, ifc.issue_Imm);
    end
  endtask

  // Four independent ADDIs issued on consecutive cycles.
  task automatic test_back_to_back();
    idle();
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) begin
        n_cmp++;
        if ({ifc.issue_valid, ifc.issue_DestRob, ifc.issue_Vj, ifc.issue_Imm}
            !== {1'b1, 4'(i - 1), 32'(10 * (i - 1) + 1), 32'(i - 1)}) begin
          n_err++; $display("FAIL b2b_%0d: got v=%b dest=%0d vj=%0d imm=%0d want 1 %0d %0d %0d", i - 1,
                            ifc.issue_valid, ifc.issue_DestRob, ifc.issue_Vj, ifc.issue_Imm,
                            i - 1, 10 * (i - 1) + 1, i - 1);
        end
      end
      if (i < 4) begin
        iq_valid = 1'b1; iq_op = OPC_ALUI; iq_rd = 5'(10 + i); iq_rs1 = 5'(i + 1);
        iq_use_rs1 = 1'b1; rf_val1 = 32'(10 * i + 1); iq_imm = 32'(i); rob_tail = 4'(i);
      end else begin
        idle();
      end
      tick();
    end
    n_cmp++;
    if (ifc.issue_valid !== 1'b0) begin
      n_err++; $display("FAIL b2b_end: got v=%b want 0", ifc.issue_valid);
    end
  endtask

  // Randomized traffic against the reference rules.
  task automatic test_random();
    logic [BW-1:0] exp_b;
    logic [11:0]   exp_c;
    logic [36:0]   o1, o2;
    logic          f, tf;
    logic [OL-1:0] e_op;
    logic [31:0]   e_imm, e_pc;
    logic [3:0]    e_dest;
    logic [36:0]   e_o1, e_o2;
    idle();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    e_op = 6'd0; e_imm = 32'd0; e_pc = 32'd0; e_dest = 4'd0;
    e_o1 = 37'd0; e_o2 = 37'd0;
    for (int n = 0; n < 400; n++) begin
      rdy = ($urandom_range(0, 9) != 0);
      jump_flag = ($urandom_range(0, 9) == 0);
      iq_valid = ($urandom_range(0, 3) != 0);
      iq_op = 6'($urandom_range(0, 63));
      iq_rd = 5'($urandom_range(0, 3));
      iq_rs1 = 5'($urandom_range(0, 3));
      iq_rs2 = 5'($urandom_range(0, 3));
      iq_use_rs1 = 1'($urandom_range(0, 1));
      iq_use_rs2 = 1'($urandom_range(0, 1));
      iq_is_ls = 1'($urandom_range(0, 1));
      iq_imm = $urandom; iq_pc = $urandom;
      rob_next_full = ($urandom_range(0, 4) == 0);
      RS_next_full = ($urandom_range(0, 4) == 0);
      LSB_next_full = ($urandom_range(0, 4) == 0);
      rf_busy1 = 1'($urandom_range(0, 1)); rf_tag1 = 4'($urandom_range(0, 3)); rf_val1 = $urandom;
      rob_ready1 = ($urandom_range(0, 3) == 0); rob_val1 = $urandom;
      if (iq_rs2 == iq_rs1) begin
        rf_busy2 = rf_busy1; rf_tag2 = rf_tag1; rf_val2 = rf_val1;
        rob_ready2 = rob_ready1; rob_val2 = rob_val1;
      end else begin
        rf_busy2 = 1'($urandom_range(0, 1)); rf_tag2 = 4'($urandom_range(0, 3)); rf_val2 = $urandom;
        rob_ready2 = ($urandom_range(0, 3) == 0); rob_val2 = $urandom;
      end
      rob_tail = 4'($urandom_range(0, 15));
      exc_valid = 1'($urandom_range(0, 1)); exc_RobId = 4'($urandom_range(0, 3)); exc_value = $urandom;
      LSB_valid = 1'($urandom_range(0, 1)); LSB_RobId = 4'($urandom_range(0, 3)); LSB_value = $urandom;

      tf = iq_is_ls ? LSB_next_full : RS_next_full;
      f = rdy && !jump_flag && iq_valid && !rob_next_full && !tf;
      exp_c = {f, f, f && (iq_rd != 5'd0), iq_rd, rob_tail};
      o1 = ref_resolve(iq_use_rs1, iq_rs1, rf_busy1, rf_tag1, rf_val1, rob_ready1, rob_val1,
                       exc_valid, exc_RobId, exc_value, LSB_valid, LSB_RobId, LSB_value);
      o2 = ref_resolve(iq_use_rs2, iq_rs2, rf_busy2, rf_tag2, rf_val2, rob_ready2, rob_val2,
                       exc_valid, exc_RobId, exc_value, LSB_valid, LSB_RobId, LSB_value);
      if (f) begin
        e_op = iq_op; e_imm = iq_imm; e_pc = iq_pc; e_dest = rob_tail; e_o1 = o1; e_o2 = o2;
      end
      exp_b = {f && !iq_is_ls, f && iq_is_ls, e_op, e_o1[35:4], e_o2[35:4], e_o1[36], e_o2[36],
               e_o1[3:0], e_o2[3:0], e_imm, e_pc, e_dest};
      #1;
      n_cmp++;
      if (comb_out() !== exp_c) begin
        n_err++; $display("FAIL rand_comb[%0d]: got %h want %h", n, comb_out(), exp_c);
      end
      tick();
      n_cmp++;
      if (bundle() !== exp_b) begin
        n_err++; $display("FAIL rand_regs[%0d]: got %h want %h", n, bundle(), exp_b);
      end
    end
    idle();
  endtask

  // Asynchronous reset drops an in-flight strobe and clears the payload.
  task automatic test_reset_midstream();
    idle();
    iq_valid = 1'b1; iq_rd = 5'd6; iq_imm = 32'h5A; rob_tail = 4'd3;
    tick();
    idle();
    n_cmp++;
    if (ifc.issue_valid !== 1'b1) begin
      n_err++; $display("FAIL midreset_pre: got v=%b want 1", ifc.issue_valid);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bundle() !== {BW{1'b0}}) begin
      n_err++; $display("FAIL midreset_regs: got %h want 0", bundle());
    end
    tick();
    rst = 1'b1;
  endtask

`ifdef ISSUE_STALL_CNT_EN
  // Stall attribution: ROB first, then the instruction's own target.
  task automatic test_stall_cnt();
    idle();
    iq_valid = 1'b1; rob_next_full = 1'b1;
    tick(); tick(); tick();
    jump_flag = 1'b1; tick(); jump_flag = 1'b0;
    iq_is_ls = 1'b1; LSB_next_full = 1'b1; tick();
    rob_next_full = 1'b0; tick(); tick();
    iq_is_ls = 1'b0; RS_next_full = 1'b1; tick();
    iq_valid = 1'b0; tick();
    idle();
    n_cmp++;
    if ({stall_rob_cnt, stall_rs_cnt, stall_lsb_cnt} !== {32'd4, 32'd1, 32'd2}) begin
      n_err++; $display("FAIL stall_cnt: got rob=%0d rs=%0d lsb=%0d want 4 1 2",
                        stall_rob_cnt, stall_rs_cnt, stall_lsb_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_bypass();
    test_lsb_stall();
    test_flush();
    test_back_to_back();
    test_random();
    test_reset_midstream();
`ifdef ISSUE_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
